// File: rtl/mist_trig_pkg.sv
// Shared encodings for the MiST frame-dump trigger: FSM states and trigger modes.
package mist_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DUMPING = 2'd2,
        ST_DONE    = 2'd3
    } trig_state_e;

    typedef enum logic [1:0] {
        MODE_IMMEDIATE = 2'd0,
        MODE_FRAME     = 2'd1,
        MODE_DOWNLOAD  = 2'd2,
        MODE_DISABLED  = 2'd3
    } trig_mode_e;

endpackage

// File: rtl/mist_sync_edge.sv
// STAGES-deep synchroniser for one asynchronous bit, plus an edge-detect register.
// Reset loads IDLE_LEVEL everywhere so leaving reset never looks like an edge.
module mist_sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = ~prev_q &  sync_q[STAGES-1];
    assign fall_o =  prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/mist_frame_trig.sv
// Frame-dump trigger: counts VGA vsync frames and opens a dump window selected by
// cfg_mode (immediate, frame range, or end of ROM download after a holdoff).
module mist_frame_trig
    import mist_trig_pkg::*;
#(
    parameter logic [31:0] HOLDOFF     = 32'd2000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs,
    input  logic        led,
    input  logic [1:0]  cfg_mode,
    input  logic [31:0] cfg_start,
    input  logic [31:0] cfg_stop,
    output logic [31:0] frame_cnt,
    output logic        vs_fall,
    output logic        dump_en,
    output logic        dump_start,
    output logic        dump_stop,
    output logic [1:0]  st
);

    logic        vs_fall_c, vs_rise_c, led_fall_c, led_rise_c;
    logic        unused_rise;

    trig_mode_e  mode_q;
    logic [31:0] start_q, stop_q;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] hold_q;
    logic        vs_fall_q, dump_en_q, dump_start_q, dump_stop_q;
    trig_state_e st_q, st_d;
    logic        stop_armed;

    mist_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_vs_sync (
        .clk_i (clk), .rst_i (rst), .d_i (vs),
        .rise_o(vs_rise_c), .fall_o(vs_fall_c)
    );

    mist_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_led_sync (
        .clk_i (clk), .rst_i (rst), .d_i (led),
        .rise_o(led_rise_c), .fall_o(led_fall_c)
    );

    assign unused_rise = vs_rise_c ^ led_rise_c;

    // Configuration is sampled only while reset is held, so a run is immune to live edits.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= trig_mode_e'(cfg_mode);
            start_q <= cfg_start;
            stop_q  <= cfg_stop;
        end
    end

    // In frame mode a stop frame at or before the start frame can never be reached in order.
    assign stop_armed  = (stop_q != 32'd0) &&
                         !((mode_q == MODE_FRAME) && (stop_q <= start_q));
    assign frame_cnt_d = vs_fall_c ? frame_cnt_q + 32'd1 : frame_cnt_q;

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE: begin
                case (mode_q)
                    MODE_IMMEDIATE: st_d = ST_DUMPING;
                    MODE_FRAME,
                    MODE_DOWNLOAD:  st_d = ST_ARMED;
                    default:        st_d = ST_DONE;
                endcase
            end
            ST_ARMED: begin
                if (mode_q == MODE_FRAME && vs_fall_c && frame_cnt_q == start_q)
                    st_d = ST_DUMPING;
                else if (mode_q == MODE_DOWNLOAD && led_fall_c && hold_q == HOLDOFF)
                    st_d = ST_DUMPING;
            end
            ST_DUMPING: begin
                if (vs_fall_c && stop_armed && frame_cnt_q == stop_q)
                    st_d = ST_DONE;
            end
            default: st_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= ST_IDLE;
            frame_cnt_q  <= 32'd0;
            hold_q       <= 32'd0;
            vs_fall_q    <= 1'b0;
            dump_en_q    <= 1'b0;
            dump_start_q <= 1'b0;
            dump_stop_q  <= 1'b0;
        end else begin
            st_q         <= st_d;
            frame_cnt_q  <= frame_cnt_d;
            hold_q       <= (hold_q == HOLDOFF) ? hold_q : hold_q + 32'd1;
            vs_fall_q    <= vs_fall_c;
            dump_en_q    <= (st_d == ST_DUMPING);
            dump_start_q <= (st_d == ST_DUMPING) && (st_q != ST_DUMPING);
            dump_stop_q  <= (st_q == ST_DUMPING) && (st_d != ST_DUMPING);
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign vs_fall    = vs_fall_q;
    assign dump_en    = dump_en_q;
    assign dump_start = dump_start_q;
    assign dump_stop  = dump_stop_q;
    assign st         = st_q;

endmodule

// File: tb/tb_mist_frame_trig.sv
// Directed bench for mist_frame_trig: reset, latency, wrap, each trigger mode, reset mid-dump.
module tb_mist_frame_trig;

    localparam int          SS = 2;
    localparam logic [31:0] HO = 32'd100;

    logic        clk, rst, vs, led;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_start, cfg_stop;
    logic [31:0] frame_cnt;
    logic        vs_fall, dump_en, dump_start, dump_stop;
    logic [1:0]  st;

    int errors = 0;
    int checks = 0;

    mist_frame_trig #(.HOLDOFF(HO), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .vs(vs), .led(led),
        .cfg_mode(cfg_mode), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .frame_cnt(frame_cnt), .vs_fall(vs_fall), .dump_en(dump_en),
        .dump_start(dump_start), .dump_stop(dump_stop), .st(st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // Event monitor sampled just after each rising edge.
    int          n_fall, n_start, n_stop, en_falls, en_low;
    logic [31:0] start_fc, stop_fc;
    logic        start_on_fall, stop_on_fall;
    logic [31:0] fc_q[$];

    always @(posedge clk) begin
        #1;
        if (vs_fall) begin
            n_fall++;
            fc_q.push_back(frame_cnt);
            if (dump_en) en_falls++;
        end
        if (dump_start) begin
            n_start++;
            start_fc = frame_cnt;
            start_on_fall = vs_fall;
        end
        if (dump_stop) begin
            n_stop++;
            stop_fc = frame_cnt;
            stop_on_fall = vs_fall;
        end
        if (!dump_en) en_low++;
    end

    task automatic clear_mon();
        n_fall = 0; n_start = 0; n_stop = 0; en_falls = 0; en_low = 0;
        start_fc = '0; stop_fc = '0; start_on_fall = 0; stop_on_fall = 0;
        fc_q.delete();
    endtask

    // Leaves the bench on the negedge right after reset release, with cfg inputs scrambled.
    task automatic do_reset(input logic [1:0] mode, input logic [31:0] start, input logic [31:0] stop);
        @(negedge clk);
        rst = 1'b1; vs = 1'b1; led = 1'b0;
        cfg_mode = mode; cfg_start = start; cfg_stop = stop;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cfg_mode = mode ^ 2'b11;
        cfg_start = $urandom_range(0, 3);
        cfg_stop = $urandom_range(0, 3);
        clear_mon();
    endtask

    task automatic vs_pulses(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) begin
            vs = 1'b0;
            repeat (lo) @(negedge clk);
            vs = 1'b1;
            repeat (hi) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; vs = 1'b0; led = 1'b1;
        cfg_mode = 2'd3; cfg_start = 32'd0; cfg_stop = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0h exp 0", frame_cnt); end
        checks++; if (vs_fall !== 1'b0) begin errors++; $display("FAIL reset_vs_fall: got %b exp 0", vs_fall); end
        checks++; if (dump_en !== 1'b0) begin errors++; $display("FAIL reset_dump_en: got %b exp 0", dump_en); end
        checks++; if ({dump_start, dump_stop} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b exp 00", {dump_start, dump_stop}); end
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_st: got %0d exp 0", st); end
        vs = 1'b1; led = 1'b0;
        do_reset(2'd3, 32'd0, 32'd0);
        repeat (6) @(negedge clk);
        checks++; if (n_fall !== 0) begin errors++; $display("FAIL reset_no_spurious_edge: got %0d falls exp 0", n_fall); end
        checks++; if (st !== 2'd3) begin errors++; $display("FAIL mode3_done: got st %0d exp 3", st); end
    endtask

    task automatic test_latency();
        int k;
        do_reset(2'd3, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        vs = 1'b0;
        k = 0;
        while (vs_fall !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++; if (k !== SS + 1) begin errors++; $display("FAIL vs_fall_latency: got %0d cycles exp %0d", k, SS + 1); end
        checks++; if (frame_cnt !== 32'd1) begin errors++; $display("FAIL frame_cnt_with_fall: got %0h exp 1", frame_cnt); end
        vs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset(2'd3, 32'd0, 32'd0);
        force dut.frame_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.frame_cnt_q;
        vs_pulses(3, 3, 3);
        repeat (4) @(negedge clk);
        checks++; if (fc_q.size() !== 3) begin errors++; $display("FAIL wrap_count: got %0d falls exp 3", fc_q.size()); end
        else begin
            checks++; if (fc_q[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_v0: got %0h exp ffffffff", fc_q[0]); end
            checks++; if (fc_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_v1: got %0h exp 0", fc_q[1]); end
            checks++; if (fc_q[2] !== 32'h1) begin errors++; $display("FAIL wrap_v2: got %0h exp 1", fc_q[2]); end
        end
    endtask

    task automatic test_frame_mode();
        do_reset(2'd1, 32'd5, 32'd8);
        @(negedge clk);
        checks++; if (st !== 2'd1) begin errors++; $display("FAIL frame_armed: got st %0d exp 1", st); end
        vs_pulses(10, 3, 3);
        repeat (4) @(negedge clk);
        checks++; if (n_fall !== 10) begin errors++; $display("FAIL frame_falls: got %0d exp 10", n_fall); end
        checks++; if (n_start !== 1 || start_fc !== 32'd6 || start_on_fall !== 1'b1) begin errors++;
            $display("FAIL frame_start: got n=%0d fc=%0d on_fall=%b exp n=1 fc=6 on_fall=1", n_start, start_fc, start_on_fall); end
        checks++; if (n_stop !== 1 || stop_fc !== 32'd9 || stop_on_fall !== 1'b1) begin errors++;
            $display("FAIL frame_stop: got n=%0d fc=%0d on_fall=%b exp n=1 fc=9 on_fall=1", n_stop, stop_fc, stop_on_fall); end
        checks++; if (en_falls !== 3) begin errors++; $display("FAIL frame_dump_frames: got %0d exp 3", en_falls); end
        checks++; if (st !== 2'd3 || dump_en !== 1'b0) begin errors++; $display("FAIL frame_done: got st=%0d en=%b exp st=3 en=0", st, dump_en); end
        checks++; if (frame_cnt !== 32'd10) begin errors++; $display("FAIL frame_cnt_final: got %0d exp 10", frame_cnt); end
    endtask

    task automatic test_download();
        int k;
        do_reset(2'd2, 32'd0, 32'd0);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 10)  led = 1'b1;
            if (c == 50)  led = 1'b0;
            if (c == 200) led = 1'b1;
            if (c == 120) begin
                checks++; if (st !== 2'd1 || n_start !== 0) begin errors++;
                    $display("FAIL download_early_fall: got st=%0d starts=%0d exp st=1 starts=0", st, n_start); end
            end
        end
        led = 1'b0;
        k = 0;
        while (dump_start !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++; if (k !== SS + 1) begin errors++; $display("FAIL download_latency: got %0d cycles exp %0d", k, SS + 1); end
        checks++; if (st !== 2'd2 || dump_en !== 1'b1) begin errors++; $display("FAIL download_dumping: got st=%0d en=%b exp st=2 en=1", st, dump_en); end
        led = 1'b1;
        repeat (5) @(negedge clk);
        led = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (n_start !== 1 || n_stop !== 0 || st !== 2'd2) begin errors++;
            $display("FAIL download_led_ignored: got starts=%0d stops=%0d st=%0d exp 1 0 2", n_start, n_stop, st); end
    endtask

    task automatic test_immediate();
        do_reset(2'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (st !== 2'd2 || dump_en !== 1'b1 || dump_start !== 1'b1) begin errors++;
            $display("FAIL immediate_entry: got st=%0d en=%b start=%b exp 2 1 1", st, dump_en, dump_start); end
        clear_mon();
        vs_pulses(1000, 2, 2);
        repeat (4) @(negedge clk);
        checks++; if (n_stop !== 0 || en_low !== 0) begin errors++;
            $display("FAIL immediate_never_stops: got stops=%0d low_cycles=%0d exp 0 0", n_stop, en_low); end
        checks++; if (frame_cnt !== 32'd1000 || st !== 2'd2) begin errors++;
            $display("FAIL immediate_frames: got cnt=%0d st=%0d exp 1000 2", frame_cnt, st); end
    endtask

    task automatic test_rst_mid_dump();
        do_reset(2'd1, 32'd3, 32'd0);
        vs_pulses(4, 3, 3);
        checks++; if (dump_en !== 1'b1 || frame_cnt !== 32'd4) begin errors++;
            $display("FAIL middump_pre: got en=%b cnt=%0d exp 1 4", dump_en, frame_cnt); end
        rst = 1'b1; cfg_mode = 2'd1; cfg_start = 32'd3; cfg_stop = 32'd0;
        @(negedge clk);
        checks++; if (dump_en !== 1'b0 || dump_stop !== 1'b0 || frame_cnt !== 32'd0 || st !== 2'd0) begin errors++;
            $display("FAIL middump_reset: got en=%b stop=%b cnt=%0d st=%0d exp 0 0 0 0", dump_en, dump_stop, frame_cnt, st); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (st !== 2'd1 || n_stop !== 0) begin errors++;
            $display("FAIL middump_rearm: got st=%0d stops=%0d exp 1 0", st, n_stop); end
    endtask

    task automatic test_start_eq_stop();
        do_reset(2'd1, 32'd2, 32'd2);
        vs_pulses(20, 3, 3);
        repeat (4) @(negedge clk);
        checks++; if (n_start !== 1 || start_fc !== 32'd3) begin errors++;
            $display("FAIL eq_start: got n=%0d fc=%0d exp 1 3", n_start, start_fc); end
        checks++; if (n_stop !== 0 || st !== 2'd2 || dump_en !== 1'b1 || frame_cnt !== 32'd20) begin errors++;
            $display("FAIL eq_never_stops: got stops=%0d st=%0d en=%b cnt=%0d exp 0 2 1 20", n_stop, st, dump_en, frame_cnt); end
    endtask

    initial begin
        rst = 1'b1; vs = 1'b1; led = 1'b0;
        cfg_mode = 2'd3; cfg_start = 32'd0; cfg_stop = 32'd0;
        clear_mon();
        test_reset();
        test_latency();
        test_wrap();
        test_frame_mode();
        test_download();
        test_immediate();
        test_rst_mid_dump();
        test_start_eq_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
